// File: rtl/keypad_scanner_pkg.sv
// Shared key codes, FSM state encoding and matrix helpers for the keypad scanner.
// Codes 0-9 are digits; '*', '#', MULTI and NONE occupy the top of the 4-bit space.
package keypad_scanner_pkg;

    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_HASH  = 4'd11;
    localparam logic [3:0] KEY_MULTI = 4'd14;
    localparam logic [3:0] KEY_NONE  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } state_t;

    // Running summary of one scan frame: closed-key count (saturating at 2) and last key seen.
    typedef struct packed {
        logic [1:0] hits;
        logic [3:0] code;
    } frame_acc_t;

    localparam frame_acc_t ACC_EMPTY = '{hits: 2'd0, code: KEY_NONE};

    function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        if (row == 2'd3) begin
            case (col)
                2'd0:    code = KEY_STAR;
                2'd1:    code = 4'd0;
                default: code = KEY_HASH;
            endcase
        end else begin
            code = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
        end
        return code;
    endfunction

    function automatic logic [9:0] digit_onehot(input logic [3:0] code);
        logic [9:0] bus;
        bus = '0;
        if (code <= 4'd9) begin
            bus[code] = 1'b1;
        end
        return bus;
    endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Generic two-flop synchroniser for a bus of independent asynchronous levels.
// Adds two cycles of latency; RST_VAL lets idle pull-up lines come out of reset inactive.
module sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// Strobes a 4x3 keypad matrix, debounces whole scan frames and drives one-hot digit, '*' and '#' levels.
// Outputs change only at frame ends; assumes SCAN_DIV >= 3 and DEBOUNCE_FRAMES >= 2.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_col_n,
    output logic [3:0] o_row_n,
    output logic [9:0] o_keypad,
    output logic       o_star,
    output logic       o_hash,
    output logic       o_key_pulse
);

    localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int                CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [2:0]        w_col_n;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_row;
    logic [3:0]        r_row_n;
    logic              w_slot_end;
    logic              w_frame_end;

    frame_acc_t        r_acc;
    frame_acc_t        w_acc_nxt;
    logic [1:0]        w_row_hits;
    logic [3:0]        w_row_code;
    logic [2:0]        w_hit_sum;
    logic [3:0]        w_frame_code;
    logic              w_single;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [3:0]        r_cand;
    logic [3:0]        w_cand_nxt;
    logic [3:0]        r_held;
    logic [3:0]        w_held_nxt;
    logic              w_pulse_nxt;

    logic [9:0]        r_keypad;
    logic              r_star;
    logic              r_hash;
    logic              r_pulse;

    sync2 #(
        .WIDTH   (3),
        .RST_VAL (3'b111)
    ) u_col_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_col_n),
        .o_q   (w_col_n)
    );

    // ---------------- row strobe ----------------
    assign w_slot_end  = (r_slot == SLOT_LAST);
    assign w_frame_end = w_slot_end && (r_row == 2'd3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_slot  <= '0;
            r_row   <= 2'd0;
            r_row_n <= 4'b1110;
        end else if (w_slot_end) begin
            r_slot  <= '0;
            r_row   <= r_row + 2'd1;
            r_row_n <= {r_row_n[2:0], r_row_n[3]};
        end else begin
            r_slot  <= r_slot + SLOT_W'(1);
        end
    end

    // ---------------- frame-code accumulation ----------------
    always_comb begin
        w_row_hits = 2'd0;
        w_row_code = KEY_NONE;
        for (int c = 0; c < 3; c++) begin
            if (!w_col_n[c]) begin
                w_row_hits = w_row_hits + 2'd1;
                w_row_code = key_at(r_row, 2'(c));
            end
        end
    end

    assign w_hit_sum = {1'b0, r_acc.hits} + {1'b0, w_row_hits};

    // The current row's sample is folded in combinationally so row 3 counts at the frame end.
    always_comb begin
        w_acc_nxt.hits = (w_hit_sum >= 3'd2) ? 2'd2 : w_hit_sum[1:0];
        w_acc_nxt.code = (w_row_hits != 2'd0) ? w_row_code : r_acc.code;
    end

    always_comb begin
        case (w_acc_nxt.hits)
            2'd0:    w_frame_code = KEY_NONE;
            2'd1:    w_frame_code = w_acc_nxt.code;
            default: w_frame_code = KEY_MULTI;
        endcase
    end

    assign w_single = (w_acc_nxt.hits == 2'd1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= ACC_EMPTY;
        end else if (w_frame_end) begin
            r_acc <= ACC_EMPTY;
        end else if (w_slot_end) begin
            r_acc <= w_acc_nxt;
        end
    end

    // ---------------- debounce FSM ----------------
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_held_nxt  = r_held;
        w_pulse_nxt = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_single) begin
                        w_state_nxt = ST_DEBOUNCE;
                        w_cand_nxt  = w_frame_code;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_frame_code == r_cand) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_state_nxt = ST_PRESSED;
                            w_held_nxt  = r_cand;
                            w_pulse_nxt = 1'b1;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (w_frame_code != r_cand) begin
                        w_state_nxt = ST_RELEASE;
                        w_cnt_nxt   = (w_frame_code == KEY_NONE) ? CNT_ONE : '0;
                    end
                end
                ST_RELEASE: begin
                    if (w_frame_code == KEY_NONE) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            w_state_nxt = ST_IDLE;
                            w_held_nxt  = KEY_NONE;
                            w_cnt_nxt   = '0;
                        end
                    end else if (w_frame_code == r_cand) begin
                        // Key came back before release was confirmed: resume without a new pulse.
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cand   <= KEY_NONE;
            r_held   <= KEY_NONE;
            r_keypad <= '0;
            r_star   <= 1'b0;
            r_hash   <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_cand   <= w_cand_nxt;
            r_held   <= w_held_nxt;
            r_keypad <= digit_onehot(w_held_nxt);
            r_star   <= (w_held_nxt == KEY_STAR);
            r_hash   <= (w_held_nxt == KEY_HASH);
            r_pulse  <= w_pulse_nxt;
        end
    end

    assign o_row_n     = r_row_n;
    assign o_keypad    = r_keypad;
    assign o_star      = r_star;
    assign o_hash      = r_hash;
    assign o_key_pulse = r_pulse;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a matrix model drives the columns, a frame-level reference predicts the outputs.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam int FRAME    = 4 * SCAN_DIV;

    localparam int M_IDLE = 0;
    localparam int M_DEB  = 1;
    localparam int M_HELD = 2;
    localparam int M_REL  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] col_n;
    logic [3:0] row_n;
    logic [9:0] keypad;
    logic       star;
    logic       hash;
    logic       key_pulse;

    logic [11:0] keys;
    logic        bounce_open;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int pulses = 0;

    logic [2:0] smp [4];
    int  m_mode;
    int  m_cand;
    int  m_cnt;
    int  m_held;
    logic exp_pulse;

    typedef struct {
        logic [11:0] keys;
        int          frames;
        int          exp_held;
        int          exp_pulses;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_FRAMES (DF)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_col_n     (col_n),
        .o_row_n     (row_n),
        .o_keypad    (keypad),
        .o_star      (star),
        .o_hash      (hash),
        .o_key_pulse (key_pulse)
    );

    function automatic int key_at(input int r, input int c);
        if (r == 3) return (c == 0) ? 10 : ((c == 1) ? 0 : 11);
        return r * 3 + c + 1;
    endfunction

    // Physical matrix: a closed key pulls its column low while its row is strobed.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!row_n[r] && keys[key_at(r, c)]) col_n[c] = 1'b0;
        if (bounce_open) col_n[1] = 1'b1;
    end

    // -1 no key, -2 several keys, else the single key seen across the four row samples.
    function automatic int frame_code();
        int n = 0;
        int k = -1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (!smp[r][c]) begin
                    n++;
                    k = key_at(r, c);
                end
        if (n == 0) return -1;
        if (n > 1) return -2;
        return k;
    endfunction

    function automatic int dut_code();
        int n = 0;
        int k = -1;
        if ($isunknown({keypad, star, hash})) return -4;
        for (int i = 0; i < 10; i++)
            if (keypad[i]) begin
                n++;
                k = i;
            end
        if (star) begin n++; k = 10; end
        if (hash) begin n++; k = 11; end
        if (n > 1) return -3;
        return k;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_cand = -1;
        m_cnt  = 0;
        m_held = -1;
        for (int r = 0; r < 4; r++) smp[r] = 3'b111;
    endtask

    task automatic model_frame(input int code);
        case (m_mode)
            M_IDLE: if (code >= 0) begin
                m_mode = M_DEB; m_cand = code; m_cnt = 1;
            end
            M_DEB: if (code == m_cand) begin
                m_cnt++;
                if (m_cnt == DF) begin
                    m_mode = M_HELD; m_held = m_cand; exp_pulse = 1'b1;
                end
            end else begin
                m_mode = M_IDLE; m_cnt = 0;
            end
            M_HELD: if (code != m_cand) begin
                m_mode = M_REL; m_cnt = (code == -1) ? 1 : 0;
            end
            default: if (code == -1) begin
                m_cnt++;
                if (m_cnt == DF) begin
                    m_mode = M_IDLE; m_held = -1; m_cnt = 0;
                end
            end else if (code == m_cand) begin
                m_mode = M_HELD;
            end else begin
                m_cnt = 0;
            end
        endcase
    endtask

    task automatic step();
        logic [3:0] exp_row;
        #1;
        // The DUT samples columns on a slot's last edge through two flops: the cycle two before it.
        if (!rst && (cyc % SCAN_DIV == SCAN_DIV - 3)) smp[(cyc / SCAN_DIV) % 4] = col_n;
        @(posedge clk);
        #1;
        exp_pulse = 1'b0;
        if (rst) begin
            model_reset();
            cyc = 0;
        end else begin
            if (cyc % FRAME == FRAME - 1) model_frame(frame_code());
            cyc++;
        end
        exp_row = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
        check("row_n", {28'd0, row_n}, {28'd0, exp_row});
        check("held_key", dut_code(), m_held);
        check("key_pulse", {31'd0, key_pulse}, {31'd0, exp_pulse});
        if (key_pulse === 1'b1) pulses++;
    endtask

    initial begin
        rst         = 1'b1;
        keys        = '0;
        bounce_open = 1'b0;
        exp_pulse   = 1'b0;
        model_reset();

        tbl[0]  = '{12'h020, 13,  5, 1};
        tbl[1]  = '{12'h000,  2,  5, 0};
        tbl[2]  = '{12'h000,  1, -1, 0};
        tbl[3]  = '{12'h006, 10, -1, 0};
        tbl[4]  = '{12'h002,  2, -1, 0};
        tbl[5]  = '{12'h002,  1,  1, 1};
        tbl[6]  = '{12'h000,  3, -1, 0};
        tbl[7]  = '{12'h400,  3, 10, 1};
        tbl[8]  = '{12'h000,  3, -1, 0};
        tbl[9]  = '{12'h800,  3, 11, 1};
        tbl[10] = '{12'h000,  3, -1, 0};
        tbl[11] = '{12'h001,  3,  0, 1};

        step();
        step();
        check("rst_row_n", {28'd0, row_n}, 32'hE);
        check("rst_keypad", {22'd0, keypad}, 32'd0);
        check("rst_star_hash_pulse", {29'd0, star, hash, key_pulse}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            keys   = tbl[i].keys;
            pulses = 0;
            for (int k = 0; k < tbl[i].frames * FRAME; k++) step();
            check($sformatf("vec%0d_held", i), dut_code(), tbl[i].exp_held);
            check($sformatf("vec%0d_pulses", i), pulses, tbl[i].exp_pulses);
        end

        // Reset while '0' is held and asserted, mid-frame.
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        step();
        check("midrst_keypad", {22'd0, keypad}, 32'd0);
        check("midrst_row_n", {28'd0, row_n}, 32'hE);
        step();
        rst    = 1'b0;
        pulses = 0;
        for (int k = 0; k < 2 * FRAME; k++) step();
        check("rearm_early", dut_code(), -1);
        for (int k = 0; k < FRAME; k++) step();
        check("rearm_held", dut_code(), 0);
        check("rearm_pulses", pulses, 1);

        // Contact bounce on '5', then a steady press.
        keys = '0;
        for (int k = 0; k < 4 * FRAME; k++) step();
        keys   = 12'h020;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            bounce_open = ((i / 5) % 2) == 1;
            step();
        end
        bounce_open = 1'b0;
        check("bounce_quiet", dut_code(), -1);
        for (int k = 0; k < 40; k++) step();
        check("bounce_two_clean", dut_code(), -1);
        for (int k = 0; k < 48; k++) step();
        check("bounce_held", dut_code(), 5);
        check("bounce_pulses", pulses, 1);

        // Random key activity, changes at arbitrary cycles.
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 29) == 0) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r < 4) keys = '0;
                else if (r < 9) keys = 12'd1 << $urandom_range(0, 11);
                else keys = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
